// File: rtl/mac_engine_ml.sv
// mac_engine_ml: N_LANES-wide signed MAC engine with HWPE-style streams.
// SIMPLE mode streams per-beat products; ACCUM mode produces one
// dot-product-plus-bias beat per job. Results are arithmetically shifted.
// Optional build macro MAC_ENGINE_ML_SAT_EN: saturate each lane result to the
// signed DW range instead of truncating to the low DW bits.
module mac_engine_ml #(
   parameter int N_LANES = 4,
   parameter int DW      = 32,
   parameter int ACC_W   = 72,
   parameter int LEN_W   = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clear_i,
   input  logic                  start_i,
   input  logic                  mode_i,
   input  logic [LEN_W-1:0]      len_i,
   input  logic [5:0]            shift_i,
   input  logic [N_LANES*DW-1:0] a_data_i,
   input  logic                  a_valid_i,
   output logic                  a_ready_o,
   input  logic [N_LANES*DW-1:0] b_data_i,
   input  logic                  b_valid_i,
   output logic                  b_ready_o,
   input  logic [N_LANES*DW-1:0] c_data_i,
   input  logic                  c_valid_i,
   output logic                  c_ready_o,
   output logic [N_LANES*DW-1:0] d_data_o,
   output logic                  d_valid_o,
   input  logic                  d_ready_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [LEN_W-1:0]      cnt_o
);

   typedef enum logic [2:0] {IDLE, RUN, BIAS, OUT, DONE} state_t;

`ifdef MAC_ENGINE_ML_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = $signed({{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}});
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
`endif

   state_t            state_reg, state_next;
   logic              mode_reg;
   logic [LEN_W-1:0]  len_reg;
   logic [5:0]        shift_reg;
   logic [LEN_W-1:0]  cnt_reg;
   logic [LEN_W-1:0]  out_cnt_reg;
   logic              d_valid_reg;
   logic              clr;
   logic              start_fire;
   logic              ab_ready;
   logic              ab_fire;
   logic              c_fire;
   logic              d_fire;

   // Shift, then either clamp to the signed DW range or keep the low DW bits.
   function automatic logic [DW-1:0] shape(input logic signed [ACC_W-1:0] v,
                                           input logic [5:0] sh);
      logic signed [ACC_W-1:0] s;
      s = v >>> sh;
`ifdef MAC_ENGINE_ML_SAT_EN
      if (s > SAT_MAX)
         s = SAT_MAX;
      else if (s < SAT_MIN)
         s = SAT_MIN;
`endif
      return s[DW-1:0];
   endfunction

   assign clr        = rst_i || clear_i;
   assign start_fire = (state_reg == IDLE) && start_i;
   // SIMPLE mode stalls on a full, unacknowledged result register.
   assign ab_ready   = (state_reg == RUN) && (cnt_reg < len_reg) &&
                       (mode_reg || !d_valid_reg || d_ready_i);
   assign ab_fire    = ab_ready && a_valid_i && b_valid_i;
   assign c_fire     = (state_reg == BIAS) && c_valid_i;
   assign d_fire     = d_valid_reg && d_ready_i;

   assign a_ready_o  = ab_ready;
   assign b_ready_o  = ab_ready;
   assign c_ready_o  = (state_reg == BIAS);
   assign d_valid_o  = d_valid_reg;
   assign busy_o     = (state_reg != IDLE);
   assign done_o     = (state_reg == DONE);
   assign cnt_o      = cnt_reg;

   // State register.
   always_ff @(posedge clk_i) begin
      if (clr)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (start_i) state_next = (len_i == '0) ? DONE : RUN;
         RUN: begin
            if (mode_reg) begin
               if (ab_fire && (cnt_reg == len_reg - LEN_W'(1))) state_next = BIAS;
            end else begin
               if (d_fire && (out_cnt_reg == len_reg - LEN_W'(1))) state_next = DONE;
            end
         end
         BIAS: if (c_fire) state_next = OUT;
         OUT:  if (d_fire) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Job configuration and beat counters.
   always_ff @(posedge clk_i) begin
      if (clr) begin
         mode_reg    <= 1'b0;
         len_reg     <= '0;
         shift_reg   <= '0;
         cnt_reg     <= '0;
         out_cnt_reg <= '0;
      end else if (start_fire) begin
         mode_reg    <= mode_i;
         len_reg     <= len_i;
         shift_reg   <= shift_i;
         cnt_reg     <= '0;
         out_cnt_reg <= '0;
      end else begin
         if (ab_fire)
            cnt_reg <= cnt_reg + LEN_W'(1);
         if (d_fire && (state_reg == RUN))
            out_cnt_reg <= out_cnt_reg + LEN_W'(1);
      end
   end

   // Result valid flag: set on a new result, cleared when taken without refill.
   always_ff @(posedge clk_i) begin
      if (clr)
         d_valid_reg <= 1'b0;
      else if ((ab_fire && !mode_reg) || c_fire)
         d_valid_reg <= 1'b1;
      else if (d_fire)
         d_valid_reg <= 1'b0;
   end

   for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
      logic signed [DW-1:0]    a_w, b_w, c_w;
      logic signed [2*DW-1:0]  prod_full;
      logic signed [ACC_W-1:0] prod_w, bias_w, acc_reg;
      logic [DW-1:0]           d_lane_reg;

      assign a_w       = a_data_i[gi*DW +: DW];
      assign b_w       = b_data_i[gi*DW +: DW];
      assign c_w       = c_data_i[gi*DW +: DW];
      assign prod_full = a_w * b_w;
      assign prod_w    = ACC_W'(prod_full);
      assign bias_w    = acc_reg + ACC_W'(c_w);

      // Lane accumulator, zeroed at job start, wraps modulo 2^ACC_W.
      always_ff @(posedge clk_i) begin
         if (clr || start_fire)
            acc_reg <= '0;
         else if (ab_fire && mode_reg)
            acc_reg <= acc_reg + prod_w;
      end

      // Lane result register, loaded from the product or the biased sum.
      always_ff @(posedge clk_i) begin
         if (clr)
            d_lane_reg <= '0;
         else if (ab_fire && !mode_reg)
            d_lane_reg <= shape(prod_w, shift_reg);
         else if (c_fire)
            d_lane_reg <= shape(bias_w, shift_reg);
      end

      assign d_data_o[gi*DW +: DW] = d_lane_reg;
   end

endmodule
